maxpool_stream: RTL and testbench

Streaming 2x2 binary max-pool over multi-channel feature maps, one image row per input beat. Even rows go into a row buffer. Each odd row is ORed vertically with the buffered row, then horizontally in column pairs, giving one pooled output row. Sits between binary conv layers in the BNN datapath and replaces fully-combinational whole-image pooling with a backpressured valid/ready stream.

---
 rtl/maxpool_stream.sv | 159 +++++++++++++++
 tb/tb_maxpool_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// Streaming 2x2 binary max-pool: even rows are buffered, odd rows are ORed with the buffer and pair-ORed into one output row.
// Define MAXPOOL_STREAM_SKID_EN for a 2-entry output FIFO with in_ready decoupled from out_ready.
module maxpool_stream #(
  parameter  int IMG_IN_SIZE  = 28,
  parameter  int CHANNELS     = 8,
  localparam int IMG_OUT_SIZE = IMG_IN_SIZE / 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNELS*IMG_IN_SIZE-1:0]  in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHANNELS*IMG_OUT_SIZE-1:0] out_data,
  output logic                             out_last,
  output logic                             frame_err
);
  localparam int CNT_W = (IMG_IN_SIZE > 2) ? $clog2(IMG_IN_SIZE) : 1;
  localparam int IN_W  = CHANNELS * IMG_IN_SIZE;
  localparam int OUT_W = CHANNELS * IMG_OUT_SIZE;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_IN_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_ODD = CNT_W'(2 * IMG_OUT_SIZE - 1);

  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [IN_W-1:0]  row_buf_q, row_buf_d;
  logic             frame_err_q, frame_err_d;
  logic             odd_phase, trailing, accept, push, push_last, early_last;
  logic [IN_W-1:0]  vert;
  logic [OUT_W-1:0] pooled;
  logic             unused_cols;

  assign odd_phase  = row_cnt_q[0];
  // Only reachable for odd sizes: the unpaired final row is swallowed.
  assign trailing   = !odd_phase && (row_cnt_q == LAST_ROW);
  assign accept     = in_valid && in_ready;
  assign push       = accept && odd_phase;
  assign early_last = in_last && (row_cnt_q != LAST_ROW);
  assign push_last  = (row_cnt_q == LAST_ODD) && !early_last;
  assign vert       = row_buf_q | in_data;
  assign unused_cols = ^vert;

  genvar gi, gj;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      for (gj = 0; gj < IMG_OUT_SIZE; gj++) begin : g_col
        assign pooled[gi*IMG_OUT_SIZE+gj] = vert[gi*IMG_IN_SIZE+2*gj] | vert[gi*IMG_IN_SIZE+2*gj+1];
      end
    end
  endgenerate

  always_comb begin
    row_cnt_d   = row_cnt_q;
    row_buf_d   = row_buf_q;
    frame_err_d = frame_err_q;
    if (accept) begin
      if (in_last || (row_cnt_q == LAST_ROW)) row_cnt_d = '0;
      else                                    row_cnt_d = row_cnt_q + CNT_W'(1);
      if (early_last)                         frame_err_d = 1'b1;
      if (!odd_phase && !trailing)            row_buf_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q   <= '0;
      row_buf_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      row_buf_q   <= row_buf_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

`ifdef MAXPOOL_STREAM_SKID_EN
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0][OUT_W-1:0] fifo_data_q, fifo_data_d;
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  pop;

  assign pop = (count_q != 2'd0) && out_ready;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = pooled;
      fifo_last_d[wr_ptr_q] = push_last;
      wr_ptr_d              = !wr_ptr_q;
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_data_q <= '0;
      fifo_last_q <= '0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
    end
  end

  // Depends only on flops, so out_ready never reaches in_ready combinationally.
  assign in_ready  = !odd_phase || (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];
`else
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (push) begin
      out_valid_d = 1'b1;
      out_data_d  = pooled;
      out_last_d  = push_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = !odd_phase || !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
`endif
endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream: a 28x8 instance and a 5x2 instance driven with random rows.
`timescale 1ns/1ps
module tb_maxpool_stream;
  localparam int NA = 28, CA = 8, NB = 5, CB = 2;
  localparam int WA = NA * CA, OA = CA * (NA / 2);
  localparam int WB = NB * CB, OB = CB * (NB / 2);
  localparam int MAXW = WA, MAXO = OA;
  typedef logic [MAXO:0] cmp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid_a, in_ready_a, in_last_a, out_valid_a, out_ready_a, out_last_a, frame_err_a;
  logic [WA-1:0] in_data_a;
  logic [OA-1:0] out_data_a;
  logic          in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, out_last_b, frame_err_b;
  logic [WB-1:0] in_data_b;
  logic [OB-1:0] out_data_b;

  maxpool_stream #(.IMG_IN_SIZE(NA), .CHANNELS(CA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .in_last(in_last_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_last(out_last_a), .frame_err(frame_err_a));

  maxpool_stream #(.IMG_IN_SIZE(NB), .CHANNELS(CB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .in_last(in_last_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_last(out_last_b), .frame_err(frame_err_b));

  int total = 0;
  int bad = 0;
  int stalls[2];
  int m_row[2];
  logic [MAXW-1:0] m_frame[2][NA];
  cmp_t q_a[$];
  cmp_t q_b[$];
  bit lat_chk[2];
  bit hold_v[2];
  cmp_t hold_d[2];
  bit done;

  task automatic chk(input string name, input cmp_t act, input cmp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: each output bit is the OR of a 2x2 window taken straight from the stored frame rows.
  function automatic logic [MAXO-1:0] pool_ref(input int n, input int ch,
                                               input logic [MAXW-1:0] top, input logic [MAXW-1:0] bot);
    logic [MAXO-1:0] res;
    res = '0;
    for (int c = 0; c < ch; c++) begin
      for (int x = 0; x < n / 2; x++) begin
        int i;
        i = c * n + 2 * x;
        res[c * (n / 2) + x] = top[i] | top[i+1] | bot[i] | bot[i+1];
      end
    end
    return res;
  endfunction

  function automatic logic [MAXW-1:0] rand_row();
    logic [MAXW-1:0] v;
    for (int i = 0; i < MAXW; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_accept(input int w, input logic [MAXW-1:0] d, input bit last);
    int n, ch, r;
    bit err;
    cmp_t e;
    n   = (w == 0) ? NA : NB;
    ch  = (w == 0) ? CA : CB;
    r   = m_row[w];
    err = last && (r != n - 1);
    m_frame[w][r] = d;
    if (r % 2 == 1) begin
      e[MAXO-1:0] = pool_ref(n, ch, m_frame[w][r-1], d);
      e[MAXO]     = (r == 2 * (n / 2) - 1) && !err;
      if (w == 0) q_a.push_back(e); else q_b.push_back(e);
      lat_chk[w] = 1'b1;
    end
    m_row[w] = (last || r == n - 1) ? 0 : r + 1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the row.
  task automatic send(input int w, input logic [MAXW-1:0] d, input bit last);
    int waited;
    bit acc, rdy;
    waited = 0;
    acc = 1'b0;
    if (w == 0) begin in_valid_a = 1'b1; in_data_a = d; in_last_a = last; end
    else        begin in_valid_b = 1'b1; in_data_b = d[WB-1:0]; in_last_b = last; end
    while (!acc) begin
      @(negedge clk);
      rdy = (w == 0) ? in_ready_a : in_ready_b;
      if (!rdy) stalls[w]++;
      @(posedge clk); #1;
      if (rdy) acc = 1'b1;
      else if (++waited > 200) begin
        total++; bad++;
        $display("FAIL send_timeout: dut %0d in_ready stuck at 0 for %0d cycles, required 1", w, waited);
        break;
      end
    end
    if (w == 0) in_valid_a = 1'b0; else in_valid_b = 1'b0;
    if (acc) model_accept(w, d, last);
  endtask

  task automatic send_frame(input int w, input int nrows, input int last_at);
    for (int r = 0; r < nrows; r++) send(w, rand_row(), r == last_at);
  endtask

  task automatic mon(input int w, input logic v, input logic rdy, input logic [MAXO-1:0] d, input logic l);
    cmp_t act, exp;
    string tag;
    tag = (w == 0) ? "a" : "b";
    act = {l, d};
    if (lat_chk[w]) begin
      chk({tag, "_latency_valid"}, cmp_t'(v), cmp_t'(1));
      lat_chk[w] = 1'b0;
    end
    if (hold_v[w]) begin
      chk({tag, "_hold_valid"}, cmp_t'(v), cmp_t'(1));
      chk({tag, "_hold_data"}, act, hold_d[w]);
    end
    hold_v[w] = v && !rdy;
    hold_d[w] = act;
    if (v && rdy) begin
      if ((w == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
        total++; bad++;
        $display("FAIL %s_extra_out: got %h with nothing expected", tag, act);
      end else begin
        exp = (w == 0) ? q_a.pop_front() : q_b.pop_front();
        chk({tag, "_out"}, act, exp);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      lat_chk[0] = 1'b0; lat_chk[1] = 1'b0;
      hold_v[0]  = 1'b0; hold_v[1]  = 1'b0;
    end else begin
      mon(0, out_valid_a, out_ready_a, out_data_a, out_last_a);
      mon(1, out_valid_b, out_ready_b, {{(MAXO-OB){1'b0}}, out_data_b}, out_last_b);
    end
  end

  task automatic drain();
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("a_queue_empty", cmp_t'(q_a.size()), cmp_t'(0));
    chk("b_queue_empty", cmp_t'(q_b.size()), cmp_t'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid_a = 1'b0; in_data_a = '0; in_last_a = 1'b0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; in_last_b = 1'b0; out_ready_b = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("a_rst_in_ready",  cmp_t'(in_ready_a),  cmp_t'(1));
    chk("a_rst_out_valid", cmp_t'(out_valid_a), cmp_t'(0));
    chk("a_rst_out_data",  cmp_t'(out_data_a),  cmp_t'(0));
    chk("a_rst_out_last",  cmp_t'(out_last_a),  cmp_t'(0));
    chk("a_rst_frame_err", cmp_t'(frame_err_a), cmp_t'(0));
    chk("b_rst_in_ready",  cmp_t'(in_ready_b),  cmp_t'(1));
    chk("b_rst_out_valid", cmp_t'(out_valid_b), cmp_t'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous frames with out_ready high; the second ends without in_last and must wrap cleanly.
    stalls[0] = 0;
    send_frame(0, NA, NA - 1);
    send_frame(0, NA, -1);
    chk("a_no_stall", cmp_t'(stalls[0]), cmp_t'(0));
    chk("a_err_clean", cmp_t'(frame_err_a), cmp_t'(0));

    // Ten cycles of backpressure while a frame streams in.
    stalls[0] = 0;
    fork
      begin
        out_ready_a = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        out_ready_a = 1'b1;
      end
      send_frame(0, NA, NA - 1);
    join
    chk("a_bp_stalled", cmp_t'(stalls[0] > 0), cmp_t'(1));

    // Early in_last on row 5, then a full frame that must start from row 0.
    send_frame(0, 6, 5);
    chk("a_err_set", cmp_t'(frame_err_a), cmp_t'(1));
    send_frame(0, NA, NA - 1);
    chk("a_err_sticky", cmp_t'(frame_err_a), cmp_t'(1));

    // Odd-size instance with random backpressure on both outputs.
    done = 1'b0;
    fork
      begin
        send_frame(1, NB, NB - 1);
        send_frame(1, NB, -1);
        chk("b_err_clean", cmp_t'(frame_err_b), cmp_t'(0));
        send_frame(1, 3, 2);
        chk("b_err_even", cmp_t'(frame_err_b), cmp_t'(1));
        send_frame(1, NB, NB - 1);
        send_frame(1, 4, 3);
        send_frame(1, NB, NB - 1);
        send_frame(0, NA, NA - 1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready_a = 1'($urandom_range(0, 1));
          out_ready_b = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Reset while a pooled row is waiting on a stalled output.
    out_ready_a = 1'b0;
    send(0, rand_row(), 1'b0);
    send(0, rand_row(), 1'b0);
    chk("a_valid_before_rst", cmp_t'(out_valid_a), cmp_t'(1));
    rst_n = 1'b0;
    #1;
    chk("a_midrst_out_valid", cmp_t'(out_valid_a), cmp_t'(0));
    chk("a_midrst_in_ready",  cmp_t'(in_ready_a),  cmp_t'(1));
    chk("a_midrst_frame_err", cmp_t'(frame_err_a), cmp_t'(0));
    q_a.delete(); q_b.delete();
    m_row[0] = 0; m_row[1] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_a = 1'b1;
    send_frame(0, NA, NA - 1);
    send_frame(1, NB, NB - 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
